sparse_stream_packer: RTL and testbench
=======================================

// Module: sparse_stream_packer
// PURPOSE
//   Lossless zero-suppression packer for DNN activation/weight streams. Each DATA_W-bit input word is
//   encoded as a variable-length codeword: an all-zero word becomes a single '0' bit, and any other
//   word becomes a '1' bit followed by the word itself. Codewords are packed MSB-first into OUT_W-bit
//   output words, with valid/ready handshakes on both sides and an explicit flush that emits a padded
//   final word with a valid-bit count. Sits between the PE output stage and the off-chip write buffer.
// PARAMETERS
//   DATA_W  16  width of one input word (codeword = 1 or DATA_W+1 bits)
//   OUT_W   64  width of one packed output word; requires OUT_W >= DATA_W+1
//   CNT_W   32  width of statistics counters (saturating)
// PORTS
//   clk        in   1                   clock, rising edge
//   rst        in   1                   asynchronous, active-low reset (0 = reset)
//   in_data    in   DATA_W              input word
//   in_valid   in   1                   in_data valid
//   in_ready   out  1                   packer can accept in_data this cycle
//   flush      in   1                   single-cycle request: terminate current packet
//   out_data   out  OUT_W               packed word; bit OUT_W-1 = earliest stream bit
//   out_nbits  out  $clog2(OUT_W+1)     number of valid MSB-aligned bits in out_data
//   out_last   out  1                   final word of a flushed packet
//   out_valid  out  1                   out_data/out_nbits/out_last valid
//   out_ready  in   1                   consumer accepts the output word
//   busy       out  1                   flush in progress
//   zero_cnt   out  CNT_W               accepted all-zero input words since reset
//   nz_cnt     out  CNT_W               accepted non-zero input words since reset
// BEHAVIOUR
//   - Reset (rst=0, async): accumulator cleared, fill=0, state=RUN, out_valid=0, out_data=0,
//     out_nbits=0, out_last=0, busy=0, counters=0. Any partial data is discarded.
//   - Accumulator: ACC_W=OUT_W+DATA_W+1 bits, filled from the MSB down; fill = number of valid bits.
//   - Codeword: zero word -> 1'b0; non-zero word -> {1'b1, in_data[DATA_W-1:0]} (in_data MSB first).
//   - in_ready = (state==RUN) && (fill < OUT_W). Accept = in_valid && in_ready; the codeword is
//     appended and fill is updated at that edge. Sustained throughput is 1 word/clk unless full words
//     back up.
//   - Output slot: a single register. It is free when out_valid=0 or out_ready=1. When fill >= OUT_W and
//     the slot is free, at that edge: out_data = acc top OUT_W bits, out_nbits = OUT_W, out_last = 0,
//     out_valid = 1; acc shifts left by OUT_W and fill -= OUT_W. Latency: the word completed by an accept
//     at edge N is visible at edge N+1 if the slot is free.
//   - out_data, out_nbits and out_last hold stable while out_valid=1 && out_ready=0.
//   - FSM RUN->FLUSH: flush=1 in RUN. An input accepted in the same cycle is included before flush.
//     flush outside RUN is ignored. busy=1 in FLUSH.
//   - FLUSH: in_ready=0. Full words drain as in RUN. When fill < OUT_W and the slot is free: emit
//     out_data = acc top OUT_W bits with zero padding, out_nbits = fill, out_last = 1, then fill=0 and
//     return to RUN. If fill==0, emit an all-zero word with nbits=0 and last=1, so every flush produces
//     exactly one last word.
//   - Counters increment on accept, saturate at all-ones, and are not cleared by flush.
//   - Full words are emitted in stream order; no bit is lost or duplicated under any out_ready pattern.
// TESTING (DATA_W=16, OUT_W=64)
//   1. Hold rst=0, then release -> out_valid=0, in_ready=1, busy=0, zero_cnt=nz_cnt=0.
//   2. 64 x 16'h0000, out_ready=1 -> one word 64'h0 with nbits=64, last=0. Then flush -> word 64'h0,
//      nbits=0, last=1. zero_cnt=64.
//   3. 4 x 16'hFFFF, then flush -> 64'hFFFF_FFFF_FFFF_FFFF (nbits=64, last=0), then
//      64'hF000_0000_0000_0000 (nbits=4, last=1). nz_cnt=4.
//   4. 16'h8001, 16'h0000, 16'h0001, flush -> single word MSB-first bits 1,8001h,0,1,0001h with zero
//      pad; nbits=35, last=1.
//   5. out_ready=0 with 8 x 16'hFFFF offered -> first word held stable; in_ready drops at fill>=64; on
//      release, words come out in order and 136 bits are conserved after flush.
//   6. Pull rst low mid-packet (fill=30, out_valid=1) -> out_valid=0 and fill=0 immediately, no output
//      after rst is released; flush asserted together with an accepted input -> that input appears in
//      the last word.

Source files
------------

// File: rtl/sparse_stream_packer_if.sv
// Stream interface for the sparse packer: input word handshake plus packed output word handshake.
// master = producer/consumer side, slave = packer side.
interface sparse_stream_packer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 64
);
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [OUT_W-1:0]           out_data;
    logic [$clog2(OUT_W+1)-1:0] out_nbits;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_nbits, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_nbits, out_last, out_valid
    );
endinterface

// File: rtl/sparse_stream_packer.sv
// Zero-suppression packer: zero word -> '0', other word -> {'1', word}; codewords packed MSB-first
// into OUT_W-bit words, with flush emitting a padded last word carrying its valid-bit count.
module sparse_stream_packer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    sparse_stream_packer_if.slave  bus,
    input  logic                   flush,
    output logic                   busy,
    output logic [CNT_W-1:0]       zero_cnt,
    output logic [CNT_W-1:0]       nz_cnt
);
    localparam int unsigned ACC_W  = OUT_W + DATA_W + 1;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);
    localparam int unsigned NB_W   = $clog2(OUT_W + 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [OUT_W-1:0]   odata_q, odata_d;
    logic [NB_W-1:0]    onbits_q, onbits_d;
    logic               olast_q, olast_d;
    logic               ovalid_q, ovalid_d;
    logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;
    logic [CNT_W-1:0]   nz_cnt_q, nz_cnt_d;

    logic               full;
    logic               slot_free;
    logic               accept;
    logic               in_zero;
    logic [ACC_W-1:0]   cw_aligned;

    assign full       = fill_q >= FILL_W'(OUT_W);
    assign slot_free  = !ovalid_q || bus.out_ready;
    assign accept     = bus.in_valid && bus.in_ready;
    assign in_zero    = bus.in_data == '0;
    // Bits below fill are always zero, so OR-ing the shifted codeword appends it.
    assign cw_aligned = {1'b1, bus.in_data, {OUT_W{1'b0}}} >> fill_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        odata_d    = odata_q;
        onbits_d   = onbits_q;
        olast_d    = olast_q;
        ovalid_d   = ovalid_q;
        zero_cnt_d = zero_cnt_q;
        nz_cnt_d   = nz_cnt_q;

        if (ovalid_q && bus.out_ready) begin
            ovalid_d = 1'b0;
        end

        if (slot_free && full) begin
            odata_d  = acc_q[ACC_W-1 -: OUT_W];
            onbits_d = NB_W'(OUT_W);
            olast_d  = 1'b0;
            ovalid_d = 1'b1;
            acc_d    = acc_q << OUT_W;
            fill_d   = fill_q - FILL_W'(OUT_W);
        end else if (state_q == StFlush && slot_free) begin
            odata_d  = acc_q[ACC_W-1 -: OUT_W];
            onbits_d = NB_W'(fill_q);
            olast_d  = 1'b1;
            ovalid_d = 1'b1;
            acc_d    = '0;
            fill_d   = '0;
            state_d  = StRun;
        end

        // Accept needs fill < OUT_W in RUN, so it never coincides with an emission above.
        if (accept) begin
            if (in_zero) begin
                fill_d = fill_q + FILL_W'(1);
                if (zero_cnt_q != '1) zero_cnt_d = zero_cnt_q + CNT_W'(1);
            end else begin
                acc_d  = acc_q | cw_aligned;
                fill_d = fill_q + FILL_W'(DATA_W + 1);
                if (nz_cnt_q != '1) nz_cnt_d = nz_cnt_q + CNT_W'(1);
            end
        end

        if (state_q == StRun && flush) begin
            state_d = StFlush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            acc_q      <= '0;
            fill_q     <= '0;
            odata_q    <= '0;
            onbits_q   <= '0;
            olast_q    <= 1'b0;
            ovalid_q   <= 1'b0;
            zero_cnt_q <= '0;
            nz_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            odata_q    <= odata_d;
            onbits_q   <= onbits_d;
            olast_q    <= olast_d;
            ovalid_q   <= ovalid_d;
            zero_cnt_q <= zero_cnt_d;
            nz_cnt_q   <= nz_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StRun) && !full;
    assign bus.out_data  = odata_q;
    assign bus.out_nbits = onbits_q;
    assign bus.out_last  = olast_q;
    assign bus.out_valid = ovalid_q;
    assign busy          = state_q == StFlush;
    assign zero_cnt      = zero_cnt_q;
    assign nz_cnt        = nz_cnt_q;
endmodule

// File: tb/tb_sparse_stream_packer.sv
// Scoreboard bench for sparse_stream_packer (DATA_W=16, OUT_W=64): stimulus pushes hand-computed
// expected words, a negedge monitor pops and compares every accepted output word.
module tb_sparse_stream_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] zero_cnt;
    logic [31:0] nz_cnt;

    sparse_stream_packer_if #(.DATA_W(16), .OUT_W(64)) bus ();

    sparse_stream_packer #(.DATA_W(16), .OUT_W(64), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .busy     (busy),
        .zero_cnt (zero_cnt),
        .nz_cnt   (nz_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  nbits;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_word(input logic [63:0] d, input int nb, input logic last);
        exp_t e;
        e.data  = d;
        e.nbits = 7'(nb);
        e.last  = last;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h nbits %0d, expected no word",
                         bus.out_data, bus.out_nbits);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", bus.out_data, mon_e.data);
                check("out_nbits", 64'(bus.out_nbits), 64'(mon_e.nbits));
                check("out_last", 64'(bus.out_last), 64'(mon_e.last));
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 500) begin
                check("send_timeout", 64'(bus.in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("busy_after_flush", 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // 1: reset
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
        check("rst_nz_cnt", 64'(nz_cnt), 64'd0);

        // 2: 64 zero words
        expect_word(64'h0, 64, 1'b0);
        for (int i = 0; i < 64; i++) send(16'h0000);
        expect_word(64'h0, 0, 1'b1);
        do_flush();
        drain();
        check("zero_cnt_64", 64'(zero_cnt), 64'd64);

        // 3: 4 x FFFF
        expect_word(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        expect_word(64'hF000_0000_0000_0000, 4, 1'b1);
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        do_flush();
        drain();
        check("nz_cnt_4", 64'(nz_cnt), 64'd4);

        // 4: mixed stream, 35 bits
        expect_word(64'hC000_A000_2000_0000, 35, 1'b1);
        send(16'h8001);
        send(16'h0000);
        send(16'h0001);
        do_flush();
        drain();
        check("nz_cnt_6", 64'(nz_cnt), 64'd6);
        check("zero_cnt_65", 64'(zero_cnt), 64'd65);

        // 5: back-pressure, 8 x FFFF = 136 bits
        bus.out_ready = 1'b0;
        expect_word(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        expect_word(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        expect_word(64'hFF00_0000_0000_0000, 8, 1'b1);
        fork
            for (int i = 0; i < 8; i++) send(16'hFFFF);
            begin
                repeat (25) @(negedge clk);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                check("stall_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                check("stall_out_nbits", 64'(bus.out_nbits), 64'd64);
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        do_flush();
        drain();
        check("nz_cnt_14", 64'(nz_cnt), 64'd14);

        // 6: async reset mid-packet (fill=30 with a word held in the slot)
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        send(16'h0001);
        for (int i = 0; i < 9; i++) send(16'h0000);
        @(negedge clk);
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_rst_nz_cnt", 64'(nz_cnt), 64'd0);
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_output_after_rst", 64'(seen), 64'd0);

        // flush together with an accepted input: {1, 1234h} = 17 bits
        @(posedge clk);
        #1;
        expect_word(64'h891A_0000_0000_0000, 17, 1'b1);
        bus.in_data  = 16'h1234;
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        check("flush_accept_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_accept_busy", 64'(busy), 64'd1);
        drain();
        check("nz_cnt_after_rst", 64'(nz_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
